// File: rtl/pipe_stage_buffer_pkg.sv
// Shared types for the two-entry pipeline stage buffer: FSM states and the
// payload record layout (field order matches the flattened payload vector).
package pipe_stage_buffer_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int CTRL_W_DEF = 3;
  localparam int CNT_W_DEF  = 8;

  // ctrl bits are {muxWB, regWrite, regWrite0}; ctrl sits in the LSBs when flattened.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] dm;
    logic [DATA_W_DEF-1:0] alu;
    logic [DATA_W_DEF-1:0] r0;
    logic [ADDR_W_DEF-1:0] rr1;
    logic [ADDR_W_DEF-1:0] waddr;
    logic [CTRL_W_DEF-1:0] ctrl;
  } payload_t;

  function automatic int payload_width(input int data_w, input int addr_w, input int ctrl_w);
    return 3 * data_w + 2 * addr_w + ctrl_w;
  endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// Load-enabled payload register with synchronous clear; one instance holds
// the head (main) entry, another the skid entry.
module pipe_payload_reg #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clock) begin
    if (i_clr) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Two-entry skid buffer between pipeline stages. in_ready is a pure state
// decode so no combinational path runs from out_ready back upstream.
module pipe_stage_buffer
  import pipe_stage_buffer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int CTRL_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  // Handshake: a transfer happens on an edge where valid && ready; valid and
  // payload are held by the sender until that edge, ready never depends on valid.
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_dm,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_r0,
  input  logic [ADDR_W-1:0] in_rr1,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_dm,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_r0,
  output logic [ADDR_W-1:0] out_rr1,
  output logic [ADDR_W-1:0] out_waddr,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int PAY_W = payload_width(DATA_W, ADDR_W, CTRL_W);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               w_accept;
  logic               w_issue;
  logic               w_main_load;
  logic               w_skid_load;
  logic               w_main_from_skid;
  logic               w_clr;
  logic [PAY_W-1:0]   w_in_pay;
  logic [PAY_W-1:0]   w_main_d;
  logic [PAY_W-1:0]   w_main_q;
  logic [PAY_W-1:0]   w_skid_q;
  logic [CTRL_W-1:0]  w_main_ctrl;
  logic [CNT_W-1:0]   r_stall_cnt;

  assign in_ready  = (r_state != FULL);
  assign out_valid = (r_state != EMPTY);

  assign w_accept = in_valid && in_ready;
  assign w_issue  = out_valid && out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_skid_load      = 1'b0;
    w_main_from_skid = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_main_load = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (w_accept && w_issue) begin
          w_main_load = 1'b1;
        end else if (w_accept) begin
          w_skid_load = 1'b1;
          w_state_nxt = FULL;
        end else if (w_issue) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        // Upstream is stalled here, so only the skid entry can refill main.
        if (w_issue) begin
          w_main_load      = 1'b1;
          w_main_from_skid = 1'b1;
          w_state_nxt      = BUSY;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
    if (flush) begin
      w_state_nxt = EMPTY;
    end
  end

  // Flush clears both entries outright; the clear wins over any load.
  assign w_clr    = reset || flush;
  assign w_in_pay = {in_dm, in_alu, in_r0, in_rr1, in_waddr, in_ctrl};
  assign w_main_d = w_main_from_skid ? w_skid_q : w_in_pay;

  pipe_payload_reg #(.W(PAY_W)) u_main_reg (
    .clock  (clock),
    .i_clr  (w_clr),
    .i_load (w_main_load),
    .i_d    (w_main_d),
    .o_q    (w_main_q)
  );

  pipe_payload_reg #(.W(PAY_W)) u_skid_reg (
    .clock  (clock),
    .i_clr  (w_clr),
    .i_load (w_skid_load),
    .i_d    (w_in_pay),
    .o_q    (w_skid_q)
  );

  assign {out_dm, out_alu, out_r0, out_rr1, out_waddr, w_main_ctrl} = w_main_q;
  assign out_ctrl = w_main_ctrl & {CTRL_W{out_valid}};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench for pipe_stage_buffer: directed scenarios plus a random run, with a
// queue-based reference model checking every cycle on the falling edge.
module tb_pipe_stage_buffer;
  import pipe_stage_buffer_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int CTRL_W = 3;
  localparam int CNT_W  = 3;
  localparam int PAY_W  = 3 * DATA_W + 2 * ADDR_W + CTRL_W;

  logic              clock = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_dm, in_alu, in_r0;
  logic [ADDR_W-1:0] in_rr1, in_waddr;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_dm, out_alu, out_r0;
  logic [ADDR_W-1:0] out_rr1, out_waddr;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  stall_cnt;

  logic [PAY_W-1:0]  exp_q[$];
  logic [CNT_W-1:0]  exp_cnt;
  logic              prev_hold = 1'b0;
  logic [PAY_W-1:0]  prev_pay;
  logic [PAY_W-1:0]  w_in_pay;
  logic [PAY_W-1:0]  w_out_pay;
  int                tests_run = 0;
  int                fails = 0;

  assign w_in_pay  = {in_dm, in_alu, in_r0, in_rr1, in_waddr, in_ctrl};
  assign w_out_pay = {out_dm, out_alu, out_r0, out_rr1, out_waddr, out_ctrl};

  pipe_stage_buffer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dm(in_dm), .in_alu(in_alu), .in_r0(in_r0),
    .in_rr1(in_rr1), .in_waddr(in_waddr), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_dm(out_dm), .out_alu(out_alu), .out_r0(out_r0),
    .out_rr1(out_rr1), .out_waddr(out_waddr), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // driver
  task automatic drive(input logic v, input logic [DATA_W-1:0] alu, input logic [CTRL_W-1:0] ctrl);
    payload_t p;
    p.dm    = DATA_W'($urandom_range(0, 65535));
    p.alu   = alu;
    p.r0    = DATA_W'($urandom_range(0, 65535));
    p.rr1   = ADDR_W'($urandom_range(0, 15));
    p.waddr = ADDR_W'($urandom_range(0, 15));
    p.ctrl  = ctrl;
    in_valid = v;
    {in_dm, in_alu, in_r0, in_rr1, in_waddr, in_ctrl} = p;
  endtask

  // scoreboard: evaluated on the falling edge, predicting the next rising edge
  always @(negedge clock) begin
    logic exp_valid;
    logic exp_ready;
    logic [PAY_W-1:0] exp_pay;
    if (reset) begin
      exp_q.delete();
      exp_cnt   = '0;
      prev_hold = 1'b0;
    end else begin
      exp_valid = (exp_q.size() != 0);
      exp_ready = (exp_q.size() < 2);
      tests_run++;
      if (out_valid !== exp_valid) begin
        fails++;
        $display("FAIL sb_out_valid: got %b expected %b at %0t", out_valid, exp_valid, $time);
      end
      tests_run++;
      if (in_ready !== exp_ready) begin
        fails++;
        $display("FAIL sb_in_ready: got %b expected %b at %0t", in_ready, exp_ready, $time);
      end
      if (!exp_valid) begin
        tests_run++;
        if (out_ctrl !== '0) begin
          fails++;
          $display("FAIL sb_ctrl_gated: got %b expected 0 at %0t", out_ctrl, $time);
        end
      end
      tests_run++;
      if (stall_cnt !== exp_cnt) begin
        fails++;
        $display("FAIL sb_stall_cnt: got %0d expected %0d at %0t", stall_cnt, exp_cnt, $time);
      end
      if (prev_hold) begin
        tests_run++;
        if (w_out_pay !== prev_pay) begin
          fails++;
          $display("FAIL sb_hold_stable: got %h expected %h at %0t", w_out_pay, prev_pay, $time);
        end
      end
      if (exp_valid && out_ready) begin
        exp_pay = exp_q.pop_front();
        tests_run++;
        if (w_out_pay !== exp_pay) begin
          fails++;
          $display("FAIL sb_issue_payload: got %h expected %h at %0t", w_out_pay, exp_pay, $time);
        end
      end
      if (flush) begin
        exp_q.delete();
      end else if (in_valid && exp_ready) begin
        exp_q.push_back(w_in_pay);
      end
      if (exp_valid && !out_ready && exp_cnt != {CNT_W{1'b1}}) begin
        exp_cnt = exp_cnt + CNT_W'(1);
      end
      prev_hold = exp_valid && !out_ready && !flush;
      prev_pay  = w_out_pay;
    end
  end

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0);
    repeat (2) tick();
    reset = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests_run++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    tests_run++;
    if (w_out_pay !== '0) begin fails++; $display("FAIL reset_out_lanes: got %h expected 0", w_out_pay); end
    tests_run++;
    if (stall_cnt !== '0) begin fails++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(1'b1, 16'h1234, 3'b010);
    tick();
    drive(1'b0, '0, '0);
    tests_run++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b expected 1", out_valid); end
    tests_run++;
    if (out_alu !== 16'h1234) begin fails++; $display("FAIL single_alu: got %h expected 1234", out_alu); end
    tests_run++;
    if (out_ctrl !== 3'b010) begin fails++; $display("FAIL single_ctrl: got %b expected 010", out_ctrl); end
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL single_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(1'b1, 16'hA001, 3'b111);
    tick();
    drive(1'b1, 16'hB002, 3'b101);
    tick();
    tests_run++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_full_ready: got %b expected 0", in_ready); end
    drive(1'b1, 16'hC003, 3'b011);
    repeat (2) tick();
    tests_run++;
    if (out_alu !== 16'hA001) begin fails++; $display("FAIL bp_head_held: got %h expected a001", out_alu); end
    out_ready = 1'b1;
    tick();
    tests_run++;
    if (out_alu !== 16'hB002) begin fails++; $display("FAIL bp_second: got %h expected b002", out_alu); end
    tests_run++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_reopen: got %b expected 1", in_ready); end
    tick();
    drive(1'b0, '0, '0);
    tests_run++;
    if (out_alu !== 16'hC003) begin fails++; $display("FAIL bp_third: got %h expected c003", out_alu); end
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 16'hD004, 3'b110);
    tick();
    drive(1'b1, 16'hE005, 3'b111);
    tick();
    flush = 1'b1;
    drive(1'b1, 16'hF006, 3'b111);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    tests_run++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_full_valid: got %b expected 0", out_valid); end
    tests_run++;
    if (out_ctrl !== '0) begin fails++; $display("FAIL flush_full_ctrl: got %b expected 0", out_ctrl); end
    tests_run++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_full_ready: got %b expected 1", in_ready); end
    out_ready = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_no_ghost: got %b expected 0", out_valid); end
    drive(1'b1, 16'h6007, 3'b001);
    tick();
    flush = 1'b1;
    drive(1'b1, 16'h7008, 3'b111);
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_busy_ready: got %b expected 1", in_ready); end
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    tests_run++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_busy_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_stall_sat();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 16'h5A5A, 3'b100);
    tick();
    drive(1'b0, '0, '0);
    repeat (3) tick();
    tests_run++;
    if (stall_cnt !== 3'd3) begin fails++; $display("FAIL stall_count3: got %0d expected 3", stall_cnt); end
    repeat (7) tick();
    tests_run++;
    if (stall_cnt !== 3'd7) begin fails++; $display("FAIL stall_saturate: got %0d expected 7", stall_cnt); end
    tick();
    tests_run++;
    if (stall_cnt !== 3'd7) begin fails++; $display("FAIL stall_hold: got %0d expected 7", stall_cnt); end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    drive(1'b1, 16'h1111, 3'b111);
    tick();
    drive(1'b1, 16'h2222, 3'b111);
    tick();
    reset = 1'b1;
    flush = 1'b1;
    drive(1'b1, 16'h3333, 3'b111);
    tick();
    reset = 1'b0;
    flush = 1'b0;
    drive(1'b0, '0, '0);
    tests_run++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL rstfull_valid: got %b expected 0", out_valid); end
    tests_run++;
    if (w_out_pay !== '0) begin fails++; $display("FAIL rstfull_lanes: got %h expected 0", w_out_pay); end
    tests_run++;
    if (stall_cnt !== '0) begin fails++; $display("FAIL rstfull_stall: got %0d expected 0", stall_cnt); end
    tests_run++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL rstfull_ready: got %b expected 1", in_ready); end
    out_ready = 1'b1;
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL rstfull_no_issue: got %b expected 0", out_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), DATA_W'($urandom_range(0, 65535)), CTRL_W'($urandom_range(0, 7)));
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 31) == 0);
      tick();
    end
    flush = 1'b0;
    drive(1'b0, '0, '0);
  endtask

  task automatic test_drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 8) begin
      tick();
      n++;
    end
    tick();
    tests_run++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL drain_timeout: got %0d left expected 0", exp_q.size()); end
    tests_run++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL drain_valid: got %b expected 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_flush();
    test_stall_sat();
    test_reset_full();
    test_random();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
